// File: rtl/ram_partition_decode_ctrl.sv
// Front-end for the partitioned RAM: registered one-hot word-line decode,
// write-port qualification and partition power-gating / wake-up sequencing.
module ram_partition_decode_ctrl #(
    parameter int unsigned DEPTH         = 32,
    parameter int unsigned INDEX         = 5,
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned NUM_RD_PORTS  = 2,
    parameter int unsigned NUM_WR_PORTS  = 2,
    parameter int unsigned NUM_PARTS     = 4,
    parameter int unsigned NUM_PARTS_LOG = 2,
    parameter int unsigned WAKE_CYCLES   = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_RD_PORTS-1:0][INDEX-1:0]            rdAddr_i,
    input  logic [NUM_RD_PORTS-1:0]                       rdEn_i,
    input  logic [NUM_WR_PORTS-1:0][INDEX-1:0]            wrAddr_i,
    input  logic [NUM_WR_PORTS-1:0]                       wrEn_i,
    input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]            dataWr_i,
    input  logic [NUM_PARTS-1:0]                          cfgMask_i,
    input  logic                                          cfgValid_i,
    output logic                                          cfgReady_o,
    input  logic                                          ramReady_i,
    output logic [NUM_RD_PORTS-1:0][DEPTH-1:0]            addr_o,
    output logic [NUM_RD_PORTS-1:0][NUM_PARTS_LOG-1:0]    rdDataPartition_o,
    output logic [NUM_WR_PORTS-1:0][DEPTH-1:0]            addrWr_o,
    output logic [NUM_WR_PORTS-1:0][WIDTH-1:0]            dataWr_o,
    output logic [NUM_WR_PORTS-1:0]                       wrEn_o,
    output logic [NUM_PARTS-1:0]                          partitionGated_o,
    output logic                                          stall_o,
    output logic                                          accessErr_o
);

    localparam int unsigned CNT_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [NUM_PARTS-1:0] PART0_ONLY = NUM_PARTS'(1);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_WAKE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [NUM_PARTS-1:0]   r_gated, w_gated_nxt;
    logic [NUM_PARTS-1:0]   r_pend, w_pend_nxt;
    logic [NUM_PARTS-1:0]   w_new_mask;

    logic [NUM_RD_PORTS-1:0][NUM_PARTS_LOG-1:0] w_rd_part;
    logic [NUM_WR_PORTS-1:0][NUM_PARTS_LOG-1:0] w_wr_part;
    logic [NUM_RD_PORTS-1:0][DEPTH-1:0]         w_rd_line;
    logic [NUM_WR_PORTS-1:0][DEPTH-1:0]         w_wr_line;
    logic [NUM_WR_PORTS-1:0]                    w_wr_dup;
    logic [NUM_WR_PORTS-1:0]                    w_wr_en;
    logic                                       w_err;

    assign w_new_mask = (cfgMask_i == '0) ? PART0_ONLY : cfgMask_i;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gated_nxt = r_gated;
        w_pend_nxt  = r_pend;
        stall_o     = 1'b1;
        cfgReady_o  = 1'b0;
        case (r_state)
            S_INIT: begin
                if (ramReady_i) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                stall_o    = 1'b0;
                cfgReady_o = 1'b1;
                if (cfgValid_i) begin
                    // Turn-offs gate now; turn-ons stay gated until the wake countdown ends.
                    w_gated_nxt = r_gated | ~w_new_mask;
                    if ((w_new_mask & r_gated) != '0) begin
                        w_state_nxt = S_WAKE;
                        w_cnt_nxt   = CNT_W'(WAKE_CYCLES);
                        w_pend_nxt  = w_new_mask;
                    end
                end
            end
            S_WAKE: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                    w_gated_nxt = ~r_pend;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++)
            w_rd_part[p] = rdAddr_i[p][INDEX-1 -: NUM_PARTS_LOG];
        for (int unsigned p = 0; p < NUM_WR_PORTS; p++)
            w_wr_part[p] = wrAddr_i[p][INDEX-1 -: NUM_PARTS_LOG];
    end

    always_comb begin
        w_err     = 1'b0;
        w_rd_line = '0;
        w_wr_line = '0;
        w_wr_dup  = '0;
        w_wr_en   = '0;
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            if (rdEn_i[p] && !stall_o) begin
                if (r_gated[w_rd_part[p]]) w_err = 1'b1;
                else                       w_rd_line[p][rdAddr_i[p]] = 1'b1;
            end
        end
        for (int unsigned p = 0; p < NUM_WR_PORTS; p++) begin
            // Highest-numbered port wins a same-index collision.
            for (int unsigned q = p + 1; q < NUM_WR_PORTS; q++)
                if (wrEn_i[q] && (wrAddr_i[q] == wrAddr_i[p])) w_wr_dup[p] = 1'b1;
            if (!stall_o) begin
                w_wr_line[p][wrAddr_i[p]] = 1'b1;
                if (wrEn_i[p] && r_gated[w_wr_part[p]]) w_err = 1'b1;
                w_wr_en[p] = wrEn_i[p] && !r_gated[w_wr_part[p]] && !w_wr_dup[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_INIT;
            r_cnt             <= '0;
            r_gated           <= '0;
            r_pend            <= '0;
            addr_o            <= '0;
            rdDataPartition_o <= '0;
            addrWr_o          <= '0;
            dataWr_o          <= '0;
            wrEn_o            <= '0;
            accessErr_o       <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_cnt             <= w_cnt_nxt;
            r_gated           <= w_gated_nxt;
            r_pend            <= w_pend_nxt;
            addr_o            <= w_rd_line;
            rdDataPartition_o <= w_rd_part;
            addrWr_o          <= w_wr_line;
            dataWr_o          <= dataWr_i;
            wrEn_o            <= w_wr_en;
            accessErr_o       <= w_err;
        end
    end

    assign partitionGated_o = r_gated;

endmodule

// File: tb/tb_ram_partition_decode_ctrl.sv
// Scoreboard bench for ram_partition_decode_ctrl: a behavioural model predicts
// every registered output one cycle ahead; predictions are queued and popped.
module tb_ram_partition_decode_ctrl;

    localparam int RP = 2, WP = 2, NP = 4, WAKE = 4;

    logic clk = 1'b0;
    logic reset;
    logic [RP-1:0][4:0]  rdAddr;
    logic [RP-1:0]       rdEn;
    logic [WP-1:0][4:0]  wrAddr;
    logic [WP-1:0]       wrEn;
    logic [WP-1:0][15:0] dataWr;
    logic [NP-1:0]       cfgMask;
    logic                cfgValid, cfgReady, ramReady;
    logic [RP-1:0][31:0] addr_o;
    logic [RP-1:0][1:0]  part_o;
    logic [WP-1:0][31:0] addrWr_o;
    logic [WP-1:0][15:0] dataWr_o;
    logic [WP-1:0]       wrEn_o;
    logic [NP-1:0]       gated_o;
    logic                stall_o, err_o;

    always #5 clk = ~clk;

    ram_partition_decode_ctrl #(
        .DEPTH(32), .INDEX(5), .WIDTH(16), .NUM_RD_PORTS(RP), .NUM_WR_PORTS(WP),
        .NUM_PARTS(NP), .NUM_PARTS_LOG(2), .WAKE_CYCLES(WAKE)
    ) dut (
        .clk(clk), .reset(reset),
        .rdAddr_i(rdAddr), .rdEn_i(rdEn),
        .wrAddr_i(wrAddr), .wrEn_i(wrEn), .dataWr_i(dataWr),
        .cfgMask_i(cfgMask), .cfgValid_i(cfgValid), .cfgReady_o(cfgReady),
        .ramReady_i(ramReady),
        .addr_o(addr_o), .rdDataPartition_o(part_o),
        .addrWr_o(addrWr_o), .dataWr_o(dataWr_o), .wrEn_o(wrEn_o),
        .partitionGated_o(gated_o), .stall_o(stall_o), .accessErr_o(err_o)
    );

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  part;
        logic [63:0] addrw;
        logic [31:0] data;
        logic [1:0]  wen;
        logic        err;
        logic [3:0]  gated;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    // Model state: 0 = INIT, 1 = RUN, 2 = WAKE
    int         m_state = 0;
    logic [3:0] m_gated = '0;
    logic [3:0] m_pend  = '0;
    int         m_until = 0;
    int         cyc     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        logic stl, g;
        logic [3:0] nm;
        int ns;
        logic [3:0] ngated, npend;
        int nuntil;
        stl = (m_state != 1);
        e.err = 1'b0;
        e.addr = '0;
        e.addrw = '0;
        e.wen = '0;
        for (int p = 0; p < RP; p++) begin
            e.part[p*2 +: 2] = rdAddr[p][4:3];
            g = m_gated[rdAddr[p][4:3]];
            if (!stl && rdEn[p]) begin
                if (g) e.err = 1'b1;
                else   e.addr[p*32 + int'(rdAddr[p])] = 1'b1;
            end
        end
        for (int p = 0; p < WP; p++) begin
            g = m_gated[wrAddr[p][4:3]];
            if (!stl) begin
                e.addrw[p*32 + int'(wrAddr[p])] = 1'b1;
                if (wrEn[p] && g) e.err = 1'b1;
            end
        end
        e.wen[1] = wrEn[1] && !stl && !m_gated[wrAddr[1][4:3]];
        e.wen[0] = wrEn[0] && !stl && !m_gated[wrAddr[0][4:3]] && !(wrEn[1] && wrAddr[1] == wrAddr[0]);
        e.data = {dataWr[1], dataWr[0]};

        ns = m_state; ngated = m_gated; npend = m_pend; nuntil = m_until;
        if (reset) begin
            ns = 0; ngated = '0; npend = '0;
            e.addr = '0; e.part = '0; e.addrw = '0; e.data = '0; e.wen = '0; e.err = 1'b0;
        end else if (m_state == 0) begin
            if (ramReady) ns = 1;
        end else if (m_state == 1) begin
            if (cfgValid) begin
                nm = (cfgMask == 4'b0) ? 4'b0001 : cfgMask;
                ngated = ~nm & 4'hF;
                if ((nm & m_gated) != 4'b0) begin
                    ngated = m_gated | ~nm;
                    ns = 2; npend = nm; nuntil = cyc + WAKE;
                end
            end
        end else begin
            if (cyc == m_until) begin
                ns = 1; ngated = ~m_pend;
            end
        end
        e.gated = ngated;
        sb.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        m_state = ns; m_gated = ngated; m_pend = npend; m_until = nuntil;

        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("addr", addr_o, e.addr);
            check("rdpart", part_o, e.part);
            check("addrWr", addrWr_o, e.addrw);
            check("dataWr", dataWr_o, e.data);
            check("wrEn", wrEn_o, e.wen);
            check("accessErr", err_o, e.err);
            check("gated", gated_o, e.gated);
            check("stall", stall_o, m_state != 1);
            check("cfgReady", cfgReady, m_state == 1);
        end
    endtask

    task automatic idle();
        rdEn = '0; wrEn = '0; cfgValid = 1'b0;
    endtask

    task automatic wait_run();
        int k;
        idle();
        k = 0;
        while (m_state != 1 && k < 20) begin
            step();
            k++;
        end
        check("wait_run", cfgReady, 1'b1);
    endtask

    initial begin
        reset = 1'b1; ramReady = 1'b0;
        rdAddr = '0; rdEn = '0; wrAddr = '0; wrEn = '0; dataWr = '0;
        cfgMask = '0; cfgValid = 1'b0;
        step(); step();
        reset = 1'b0;
        step(); step();
        ramReady = 1'b1;
        step();

        // Read decode
        rdAddr[0] = 5'd13; rdEn[0] = 1'b1; rdAddr[1] = 5'd30; rdEn[1] = 1'b1;
        step();
        check("rd13_line", addr_o[0], 64'h0000_2000);
        check("rd13_part", part_o[0], 64'd1);
        idle();

        // Gate upper partitions; same-cycle write sees the old mask
        cfgMask = 4'b0011; cfgValid = 1'b1;
        wrAddr[0] = 5'd20; wrEn[0] = 1'b1; dataWr[0] = 16'hBEEF;
        step();
        cfgValid = 1'b0;
        rdAddr[1] = 5'd25; rdEn[1] = 1'b1;
        step();
        check("gated_1100", gated_o, 64'hC);
        idle();

        // Wake everything; accesses during the stall are suppressed
        cfgMask = 4'b1111; cfgValid = 1'b1;
        step();
        cfgValid = 1'b0;
        wrAddr[1] = 5'd2; wrEn[1] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        idle();

        // Duplicate write index
        wrAddr[0] = 5'd7; wrAddr[1] = 5'd7; wrEn = 2'b11;
        dataWr[0] = 16'h1111; dataWr[1] = 16'h2222;
        step();
        wrAddr[0] = 5'd3; wrAddr[1] = 5'd9;
        step();
        idle();

        // Random traffic with occasional reconfiguration
        for (int i = 0; i < 60; i++) begin
            for (int p = 0; p < 2; p++) begin
                rdAddr[p] = 5'($urandom_range(0, 31));
                wrAddr[p] = 5'($urandom_range(0, 31));
                dataWr[p] = 16'($urandom);
            end
            rdEn = 2'($urandom);
            wrEn = 2'($urandom);
            cfgValid = ($urandom_range(0, 7) == 0);
            cfgMask = 4'($urandom);
            step();
        end

        // Zero mask selects partition 0 only, then reset in mid-wake
        wait_run();
        cfgMask = 4'b1111; cfgValid = 1'b1;
        step();
        wait_run();
        cfgMask = 4'b0000; cfgValid = 1'b1;
        step();
        check("gated_1110", gated_o, 64'hE);
        cfgMask = 4'b1111;
        step();
        idle();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_gated", gated_o, 64'h0);
        check("rst_stall", stall_o, 1'b1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
